// File: rtl/wasm_pkg.sv
// Shared types for the call/return frame sequencer.
// Holds the frame layout pushed to the call stack, the trap codes, and the FSM state encoding.
package wasm_pkg;

  localparam int unsigned FRAME_ADDR_W = 16;
  localparam int unsigned FRAME_CNT_W  = 8;

  typedef enum logic [1:0] {
    TRAP_NONE                 = 2'd0,
    TRAP_CALL_STACK_EXHAUSTED = 2'd1,
    TRAP_STACK_UNDERFLOW      = 2'd2
  } trap_t;

  typedef struct packed {
    logic [31:0]             return_pc;
    logic [FRAME_ADDR_W-1:0] locals_base;
    logic [FRAME_ADDR_W-1:0] stack_height;
  } frame_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StCallZero,
    StRetCopy,
    StDone
  } frame_state_t;

  // Callee frame: locals start at the first parameter, and the caller's height is the same point.
  function automatic frame_entry_t make_frame(input logic [31:0]             ret_pc,
                                              input logic [FRAME_ADDR_W-1:0] base);
    frame_entry_t f;
    f.return_pc    = ret_pc;
    f.locals_base  = base;
    f.stack_height = base;
    return f;
  endfunction

endpackage

// File: rtl/wasm_frame_ctrl_if.sv
// Bundle between the control unit / call stack / operand memory and the frame sequencer.
// The master modport is the sequencer; the slave modport is everything around it.
interface wasm_frame_ctrl_if #(
  parameter int unsigned ADDR_W = wasm_pkg::FRAME_ADDR_W,
  parameter int unsigned CNT_W  = wasm_pkg::FRAME_CNT_W
) ();
  import wasm_pkg::*;

  // Control unit side
  logic              call_req;
  logic              ret_req;
  logic [31:0]       target_pc;
  logic [31:0]       return_pc;
  logic [CNT_W-1:0]  param_count;
  logic [CNT_W-1:0]  local_count;
  logic [CNT_W-1:0]  result_count;
  logic [ADDR_W-1:0] osp_in;
  logic              busy;
  logic              done;
  logic              halt;
  trap_t             trap;
  logic [31:0]       new_pc;
  logic              osp_wr_en;
  logic [ADDR_W-1:0] osp_out;

  // Operand stack memory (combinational read)
  logic              os_wr_en;
  logic [ADDR_W-1:0] os_wr_addr;
  logic [31:0]       os_wr_data;
  logic [ADDR_W-1:0] os_rd_addr;
  logic [31:0]       os_rd_data;

  // Call stack
  logic              cs_push_en;
  frame_entry_t      cs_push_data;
  logic              cs_pop_en;
  frame_entry_t      cs_top;
  logic              cs_empty;
  logic              cs_full;

  modport master (
    input  call_req, ret_req, target_pc, return_pc, param_count, local_count, result_count,
    input  osp_in, os_rd_data, cs_top, cs_empty, cs_full,
    output busy, done, halt, trap, new_pc, osp_wr_en, osp_out,
    output os_wr_en, os_wr_addr, os_wr_data, os_rd_addr,
    output cs_push_en, cs_push_data, cs_pop_en
  );

  modport slave (
    output call_req, ret_req, target_pc, return_pc, param_count, local_count, result_count,
    output osp_in, os_rd_data, cs_top, cs_empty, cs_full,
    input  busy, done, halt, trap, new_pc, osp_wr_en, osp_out,
    input  os_wr_en, os_wr_addr, os_wr_data, os_rd_addr,
    input  cs_push_en, cs_push_data, cs_pop_en
  );

endinterface

// File: rtl/wasm_frame_ctrl.sv
// Call/return sequencer: pushes/pops call-stack frames, zero-fills callee locals on call and
// copies results down to the caller's stack height on return. ADDR_W must match the package.
module wasm_frame_ctrl #(
  parameter int unsigned ADDR_W = wasm_pkg::FRAME_ADDR_W,
  parameter int unsigned CNT_W  = wasm_pkg::FRAME_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  wasm_frame_ctrl_if.master bus
);
  import wasm_pkg::*;

  frame_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  // Zero-fill base on call, copy destination on return; osp_out is always base_q + n_q.
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [31:0]       pc_q, pc_d;
  trap_t             trap_q, trap_d;
  logic              halt_q, halt_d;

  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] ret_avail;
  logic              last_word;

  assign frame_base = bus.osp_in - ADDR_W'(bus.param_count);
  assign ret_avail  = bus.osp_in - bus.cs_top.stack_height;
  assign last_word  = (cnt_q == n_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      src_q   <= '0;
      pc_q    <= '0;
      trap_q  <= TRAP_NONE;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      base_q  <= base_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    base_d  = base_q;
    src_d   = src_q;
    pc_d    = pc_q;
    trap_d  = trap_q;
    halt_d  = halt_q;

    bus.busy         = (state_q != StIdle);
    bus.done         = 1'b0;
    bus.halt         = 1'b0;
    bus.trap         = TRAP_NONE;
    bus.new_pc       = '0;
    bus.osp_wr_en    = 1'b0;
    bus.osp_out      = '0;
    bus.os_wr_en     = 1'b0;
    bus.os_wr_addr   = '0;
    bus.os_wr_data   = '0;
    bus.os_rd_addr   = '0;
    bus.cs_push_en   = 1'b0;
    bus.cs_push_data = '0;
    bus.cs_pop_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        trap_d = TRAP_NONE;
        halt_d = 1'b0;
        if (bus.call_req) begin
          pc_d   = bus.target_pc;
          base_d = bus.osp_in;
          if (ADDR_W'(bus.param_count) > bus.osp_in) begin
            trap_d  = TRAP_STACK_UNDERFLOW;
            n_d     = '0;
            state_d = StDone;
          end else if (bus.cs_full) begin
            trap_d  = TRAP_CALL_STACK_EXHAUSTED;
            n_d     = '0;
            state_d = StDone;
          end else begin
            bus.cs_push_en   = 1'b1;
            bus.cs_push_data = make_frame(bus.return_pc, frame_base);
            n_d              = bus.local_count;
            state_d          = (bus.local_count == '0) ? StDone : StCallZero;
          end
        end else if (bus.ret_req) begin
          if (bus.cs_empty) begin
            // Returning from the outermost frame: leave the stack height untouched.
            halt_d  = 1'b1;
            pc_d    = '0;
            base_d  = bus.osp_in;
            n_d     = '0;
            state_d = StDone;
          end else begin
            bus.cs_pop_en = 1'b1;
            pc_d          = bus.cs_top.return_pc;
            base_d        = bus.cs_top.stack_height;
            src_d         = bus.osp_in - ADDR_W'(bus.result_count);
            if (ADDR_W'(bus.result_count) > ret_avail) begin
              trap_d  = TRAP_STACK_UNDERFLOW;
              n_d     = '0;
              state_d = StDone;
            end else begin
              n_d     = bus.result_count;
              state_d = (bus.result_count == '0) ? StDone : StRetCopy;
            end
          end
        end
      end

      StCallZero: begin
        bus.os_wr_en   = 1'b1;
        bus.os_wr_addr = base_q + ADDR_W'(cnt_q);
        bus.os_wr_data = '0;
        cnt_d          = cnt_q + CNT_W'(1);
        if (last_word) begin
          state_d = StDone;
        end
      end

      StRetCopy: begin
        // Ascending copy is safe for overlapping ranges since destination never exceeds source.
        bus.os_rd_addr = src_q + ADDR_W'(cnt_q);
        bus.os_wr_en   = 1'b1;
        bus.os_wr_addr = base_q + ADDR_W'(cnt_q);
        bus.os_wr_data = bus.os_rd_data;
        cnt_d          = cnt_q + CNT_W'(1);
        if (last_word) begin
          state_d = StDone;
        end
      end

      StDone: begin
        bus.done      = 1'b1;
        bus.halt      = halt_q;
        bus.trap      = trap_q;
        bus.new_pc    = pc_q;
        bus.osp_out   = base_q + ADDR_W'(n_q);
        bus.osp_wr_en = (trap_q == TRAP_NONE);
        state_d       = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_wasm_frame_ctrl.sv
// Directed bench for the call/return frame sequencer with hand-computed expectations.
// The call stack is driven directly; operand reads come from a preset table, writes are logged.
module tb_wasm_frame_ctrl;
  import wasm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wasm_frame_ctrl_if #(.ADDR_W(16), .CNT_W(8)) bus ();

  wasm_frame_ctrl #(.ADDR_W(16), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] rd_mem [64];
  assign bus.os_rd_data = rd_mem[bus.os_rd_addr[5:0]];

  int total = 0;
  int bad   = 0;

  // Event log captured at each rising edge
  int           cyc      = 0;
  int           done_cnt = 0;
  int           push_cnt = 0;
  int           pop_cnt  = 0;
  int           wr_n     = 0;
  int           done_cyc = 0;
  logic [31:0]  d_pc;
  logic [15:0]  d_osp;
  trap_t        d_trap;
  logic         d_halt;
  logic         d_oen;
  frame_entry_t last_push;
  logic [15:0]  wa [64];
  logic [31:0]  wd [64];
  int           wc [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc + 1;
        d_pc     <= bus.new_pc;
        d_osp    <= bus.osp_out;
        d_trap   <= bus.trap;
        d_halt   <= bus.halt;
        d_oen    <= bus.osp_wr_en;
      end
      if (bus.cs_push_en) begin
        push_cnt  <= push_cnt + 1;
        last_push <= bus.cs_push_data;
      end
      if (bus.cs_pop_en) pop_cnt <= pop_cnt + 1;
      if (bus.os_wr_en && wr_n < 64) begin
        wa[wr_n] <= bus.os_wr_addr;
        wd[wr_n] <= bus.os_wr_data;
        wc[wr_n] <= cyc + 1;
        wr_n     <= wr_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Call with requests already set; returns the sampling cycle E and done latency.
  task automatic run_req(input string tag, output int e, output int lat);
    int d0;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    e = cyc;
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    for (int k = 0; k < 40 && done_cnt == d0; k++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    lat = done_cyc - e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, lat, p0, q0, w0, d0;
    frame_entry_t exp_frame;

    for (int i = 0; i < 64; i++) rd_mem[i] = 32'h0;
    rd_mem[13] = 32'hAA;
    rd_mem[14] = 32'hBB;

    bus.call_req     = 1'b0;
    bus.ret_req      = 1'b0;
    bus.target_pc    = '0;
    bus.return_pc    = '0;
    bus.param_count  = '0;
    bus.local_count  = '0;
    bus.result_count = '0;
    bus.osp_in       = '0;
    bus.cs_top       = '0;
    bus.cs_empty     = 1'b0;
    bus.cs_full      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_trap", 64'(bus.trap), 64'(TRAP_NONE));
    check("rst_owr", 64'(bus.os_wr_en), 64'd0);
    check("rst_push", 64'(bus.cs_push_en), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Call: three locals zero-filled above two params
    p0 = push_cnt; w0 = wr_n;
    bus.osp_in = 16'd10; bus.param_count = 8'd2; bus.local_count = 8'd3;
    bus.target_pc = 32'h40; bus.return_pc = 32'h1C; bus.call_req = 1'b1;
    run_req("call1", e, lat);
    exp_frame = '{return_pc: 32'h1C, locals_base: 16'd8, stack_height: 16'd8};
    check("call1_push_n", 64'(push_cnt - p0), 64'd1);
    check("call1_frame", 64'(last_push), 64'(exp_frame));
    check("call1_wr_n", 64'(wr_n - w0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("call1_wa", 64'(wa[w0+i]), 64'(10 + i));
      check("call1_wd", 64'(wd[w0+i]), 64'd0);
      check("call1_wc", 64'(wc[w0+i] - e), 64'(i + 1));
    end
    check("call1_lat", 64'(lat), 64'd4);
    check("call1_pc", 64'(d_pc), 64'h40);
    check("call1_osp", 64'(d_osp), 64'd13);
    check("call1_trap", 64'(d_trap), 64'(TRAP_NONE));
    check("call1_oen", 64'(d_oen), 64'd1);
    check("call1_busy", 64'(bus.busy), 64'd0);

    // Return two results down to height 8
    q0 = pop_cnt; p0 = push_cnt; w0 = wr_n;
    bus.cs_top = exp_frame; bus.osp_in = 16'd15; bus.result_count = 8'd2; bus.ret_req = 1'b1;
    run_req("ret1", e, lat);
    check("ret1_pop", 64'(pop_cnt - q0), 64'd1);
    check("ret1_push", 64'(push_cnt - p0), 64'd0);
    check("ret1_wr_n", 64'(wr_n - w0), 64'd2);
    check("ret1_wa0", 64'(wa[w0]), 64'd8);
    check("ret1_wd0", 64'(wd[w0]), 64'hAA);
    check("ret1_wa1", 64'(wa[w0+1]), 64'd9);
    check("ret1_wd1", 64'(wd[w0+1]), 64'hBB);
    check("ret1_lat", 64'(lat), 64'd3);
    check("ret1_pc", 64'(d_pc), 64'h1C);
    check("ret1_osp", 64'(d_osp), 64'd10);
    check("ret1_oen", 64'(d_oen), 64'd1);

    // Call with full call stack
    p0 = push_cnt; w0 = wr_n;
    bus.cs_full = 1'b1; bus.osp_in = 16'd10; bus.param_count = 8'd1; bus.local_count = 8'd2;
    bus.call_req = 1'b1;
    run_req("full", e, lat);
    check("full_push", 64'(push_cnt - p0), 64'd0);
    check("full_wr", 64'(wr_n - w0), 64'd0);
    check("full_lat", 64'(lat), 64'd1);
    check("full_trap", 64'(d_trap), 64'(TRAP_CALL_STACK_EXHAUSTED));
    check("full_oen", 64'(d_oen), 64'd0);
    bus.cs_full = 1'b0;

    // Call with more params than stack height
    p0 = push_cnt;
    bus.osp_in = 16'd3; bus.param_count = 8'd5; bus.local_count = 8'd1; bus.call_req = 1'b1;
    run_req("cund", e, lat);
    check("cund_push", 64'(push_cnt - p0), 64'd0);
    check("cund_trap", 64'(d_trap), 64'(TRAP_STACK_UNDERFLOW));
    check("cund_oen", 64'(d_oen), 64'd0);

    // Return from outermost frame
    q0 = pop_cnt;
    bus.cs_empty = 1'b1; bus.osp_in = 16'd7; bus.result_count = 8'd1; bus.ret_req = 1'b1;
    run_req("halt", e, lat);
    check("halt_lat", 64'(lat), 64'd1);
    check("halt_halt", 64'(d_halt), 64'd1);
    check("halt_pop", 64'(pop_cnt - q0), 64'd0);
    check("halt_trap", 64'(d_trap), 64'(TRAP_NONE));
    check("halt_pc", 64'(d_pc), 64'd0);
    check("halt_osp", 64'(d_osp), 64'd7);
    check("halt_oen", 64'(d_oen), 64'd1);

    // Both requests: call takes priority
    p0 = push_cnt; q0 = pop_cnt;
    bus.osp_in = 16'd4; bus.param_count = 8'd0; bus.local_count = 8'd0; bus.target_pc = 32'h80;
    bus.call_req = 1'b1; bus.ret_req = 1'b1;
    run_req("both", e, lat);
    check("both_push", 64'(push_cnt - p0), 64'd1);
    check("both_pop", 64'(pop_cnt - q0), 64'd0);
    check("both_halt", 64'(d_halt), 64'd0);
    check("both_pc", 64'(d_pc), 64'h80);
    check("both_osp", 64'(d_osp), 64'd4);
    bus.cs_empty = 1'b0;

    // Return with too few values above caller height
    q0 = pop_cnt; w0 = wr_n;
    bus.cs_top = exp_frame; bus.osp_in = 16'd9; bus.result_count = 8'd3; bus.ret_req = 1'b1;
    run_req("rund", e, lat);
    check("rund_pop", 64'(pop_cnt - q0), 64'd1);
    check("rund_trap", 64'(d_trap), 64'(TRAP_STACK_UNDERFLOW));
    check("rund_wr", 64'(wr_n - w0), 64'd0);
    check("rund_oen", 64'(d_oen), 64'd0);
    check("rund_lat", 64'(lat), 64'd1);

    // Reset in the middle of a zero-fill
    w0 = wr_n; d0 = done_cnt;
    bus.osp_in = 16'd20; bus.param_count = 8'd0; bus.local_count = 8'd5; bus.call_req = 1'b1;
    @(posedge clk);
    #1;
    bus.call_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("abort_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_owr", 64'(bus.os_wr_en), 64'd0);
    check("abort_oen", 64'(bus.osp_wr_en), 64'd0);
    check("abort_wr", 64'(wr_n - w0), 64'd2);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_nodone", 64'(done_cnt - d0), 64'd0);

    bus.osp_in = 16'd30; bus.local_count = 8'd0; bus.target_pc = 32'h100; bus.call_req = 1'b1;
    run_req("post", e, lat);
    check("post_lat", 64'(lat), 64'd1);
    check("post_pc", 64'(d_pc), 64'h100);
    check("post_osp", 64'(d_osp), 64'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
